alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (AND/OR/ADD/SUB/shift datapath) between two requesters: port 0 (execute stage) and port 1 (multdiv iterative engine).
- Latches the winning request's operands into the ALU, captures the result, and holds it until the winner accepts it.
- Uses round-robin arbitration with valid/ready handshakes and allows one operation in flight.

Parameters:
- WIDTH, 32, operand/result width
- OPC_W, 5, ALU opcode width
- SHAMT_W, 5, shift amount width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; handshake when valid&ready
- req0_opcode / req1_opcode  in  OPC_W  ALU opcode
- req0_shamt / req1_shamt  in  SHAMT_W  shift amount
- req0_a / req1_a  in  WIDTH  operand A
- req0_b / req1_b  in  WIDTH  operand B
- rsp_valid  out  2  one-hot result valid to the owner
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  WIDTH  captured ALU result, shared bus
- rsp_flags  out  3  {overflow, isLessThan, isNotEqual} captured with the result
- alu_opcode  out  OPC_W  to the ALU
- alu_shamt  out  SHAMT_W  to the ALU
- alu_a, alu_b  out  WIDTH  to the ALU
- alu_result  in  WIDTH  from the ALU (combinational)
- alu_ovf, alu_lt, alu_ne  in  1  ALU flags
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_flags=0.
  - alu_* outputs=0, last_grant=1, so requester 0 is favoured first.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - req_ready is combinational: one-hot grant to the winner of req_valid, else 0.
  - Round-robin: if both requests are valid, grant goes to the requester != last_grant.
  - On handshake: latch opcode/shamt/a/b into the alu_* registers, record owner, set last_grant=owner, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs are stable from the latched registers.
  - At the clock edge: rsp_data<=alu_result, rsp_flags<={alu_ovf,alu_lt,alu_ne}, rsp_valid[owner]<=1, go to HOLD.
- HOLD:
  - rsp_valid[owner]=1; rsp_data and rsp_flags are held stable.
  - On rsp_ready[owner]: clear rsp_valid and go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency:
  - Handshake in cycle N → rsp_valid high in cycle N+2.
  - Minimum issue interval is 3 cycles, since req_ready is 0 in EXEC and HOLD.
- alu_* registers keep their last value after completion; no spurious zeroing.
- Single requester valid: granted regardless of last_grant.
- A requester dropping req_valid before the grant is legal; no state change.
- rsp_ready asserted in EXEC has no effect; acceptance counts only in HOLD.
- Synchronous reset mid-operation (EXEC or HOLD):
  - Aborts the operation and returns to IDLE.
  - Pending result is discarded; rsp_valid=0 in the next cycle.
- busy=1 in EXEC and HOLD.

Optional Feature:
- Macro ARB_BYPASS_HOLD_EN.
- Defined:
  - If rsp_ready[owner]=1 during EXEC, the result is delivered combinationally from alu_result.
  - In that case rsp_valid[owner]=1 in EXEC and the FSM returns directly to IDLE, giving latency N+1 and an issue interval of 2.
  - Otherwise it behaves as normal and enters HOLD.
- Undefined: behaviour exactly as above; rsp_valid is always registered.

Test Plan:
- Reset then single request: req_valid=01, req0 AND a=0xF0F0F0F0 b=0xFF00FF00 → req_ready=01 same cycle; rsp_valid=01 at N+2 with rsp_data=0xF000F000; rsp_ready → IDLE.
- Contention alternation: req_valid=11 held for 4 operations, rsp_ready tied high → grants in the order 0,1,0,1; each rsp_data matches the owner's operands.
- Backpressure: hold rsp_ready=00 for 5 cycles in HOLD while changing alu_result → rsp_data stable; req_ready=00 throughout; the new request waits.
- Flags: req1 SUB a=0x7FFFFFFF b=0xFFFFFFFF → rsp_valid=10, rsp_flags overflow=1, rsp_data=0x80000000.
- Reset mid-op: drive reset_n=0 in EXEC → next cycle state=IDLE, rsp_valid=00, busy=0; then last_grant=1, so a contending 11 grants requester 0.
- ARB_BYPASS_HOLD_EN: rsp_ready=01 held, req0 ADD 3+4 → rsp_valid=01 with rsp_data=7 at N+1; the next handshake is possible at N+2.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Optional `ARB_BYPASS_HOLD_EN delivers the result straight from the ALU during EXEC when the owner is ready.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPC_W   = 5,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [OPC_W-1:0]   req0_opcode,
  input  logic [OPC_W-1:0]   req1_opcode,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [2:0]         rsp_flags,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_ovf,
  input  logic               alu_lt,
  input  logic               alu_ne,
  output logic               busy,
  output logic [1:0]         fsm_state
);

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // a result transfers on a cycle where rsp_valid[i] & rsp_ready[i].
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

  state_t             state, state_next;
  logic               last_grant;
  logic               owner;
  logic [1:0]         grant;
  logic               handshake;
  logic               bypass;
  logic [1:0]         rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [2:0]         rsp_flags_q;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  assign handshake = (state == IDLE) && (req_valid != 2'b00);

`ifdef ARB_BYPASS_HOLD_EN
  assign bypass = (state == EXEC) && rsp_ready[owner];
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = bypass ? IDLE : HOLD;
      HOLD:    if (rsp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      alu_opcode  <= '0;
      alu_shamt   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_flags_q <= 3'b000;
    end else begin
      if (handshake) begin
        alu_opcode <= grant[1] ? req1_opcode : req0_opcode;
        alu_shamt  <= grant[1] ? req1_shamt  : req0_shamt;
        alu_a      <= grant[1] ? req1_a      : req0_a;
        alu_b      <= grant[1] ? req1_b      : req0_b;
        owner      <= grant[1];
        last_grant <= grant[1];
      end
      if (state == EXEC && !bypass) begin
        rsp_data_q  <= alu_result;
        rsp_flags_q <= {alu_ovf, alu_lt, alu_ne};
        rsp_valid_q <= owner ? 2'b10 : 2'b01;
      end
      if (state == HOLD && rsp_ready[owner]) rsp_valid_q <= 2'b00;
    end
  end

  always_comb begin
    req_ready = (state == IDLE) ? grant : 2'b00;
    busy      = (state != IDLE);
    fsm_state = state;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_flags = rsp_flags_q;
    if (bypass) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
      rsp_data  = alu_result;
      rsp_flags = {alu_ovf, alu_lt, alu_ne};
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: random and directed requests scored against a cycle-timestamp reference model.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready, fsm_state;
  logic [4:0]   req0_opcode, req1_opcode, req0_shamt, req1_shamt;
  logic [W-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_result;
  logic [2:0]   rsp_flags;
  logic [4:0]   alu_opcode, alu_shamt;
  logic         alu_ovf, alu_lt, alu_ne, busy;
  logic         noise_en = 1'b0;
  logic [W-1:0] noise = '0;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_lt(alu_lt), .alu_ne(alu_ne),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // Reference ALU: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLL, 5 SRL, 6 SRA; returns {ovf, lt, ne, result}.
  function automatic logic [34:0] alu_ref(input logic [4:0] op, input logic [4:0] sh,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, full;
    logic [W-1:0] r;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    case (op)
      5'd0: r = a & b;
      5'd1: r = a | b;
      5'd2: begin full = sa + sb; r = full[W-1:0]; ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      5'd3: begin full = sa - sb; r = full[W-1:0]; ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      5'd4: r = a << sh;
      5'd5: r = a >> sh;
      5'd6: r = $signed(a) >>> sh;
      default: r = '0;
    endcase
    return {ovf, (sa < sb), (a != b), r};
  endfunction

  // Stand-in ALU; noise perturbs its output while a result is being held so stability is exercised.
  logic [34:0] alu_out;
  always_comb begin
    alu_out    = alu_ref(alu_opcode, alu_shamt, alu_a, alu_b);
    alu_result = alu_out[31:0] ^ ((noise_en && rsp_valid != 2'b00) ? noise : '0);
    {alu_ovf, alu_lt, alu_ne} = alu_out[34:32];
  end

  always @(posedge clock) noise <= $urandom();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / monitor: expected {flags, data} pushed at request handshake, popped at result accept
  logic [34:0] exp_q[$];
  int          cyc = 0;
  int          issue_cyc = 0;
  logic        in_flight = 1'b0;
  logic        m_owner = 1'b0;
  logic        m_last = 1'b1;
  logic        pend_rst = 1'b0;
  logic [4:0]  e_op = '0, e_sh = '0;
  logic [W-1:0] e_a = '0, e_b = '0;

  always @(negedge clock) begin
    logic [1:0] exp_ready, exp_rv;
    logic       win, show;
    cyc++;
    if (!reset_n) begin
      in_flight = 1'b0;
      exp_q.delete();
      m_last = 1'b1;
      e_op = '0; e_sh = '0; e_a = '0; e_b = '0;
      pend_rst = 1'b1;
    end else begin
      if (pend_rst) begin
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("reset_state", 64'(fsm_state), 64'd0);
        pend_rst = 1'b0;
      end
      chk("alu_regs", {alu_opcode, alu_shamt, alu_a, alu_b}, {e_op, e_sh, e_a, e_b});
      chk("busy", 64'(busy), 64'(in_flight));

      win = 1'b0;
      if (req_valid == 2'b11) win = ~m_last;
      else if (req_valid == 2'b10) win = 1'b1;
      exp_ready = (in_flight || req_valid == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));

      show = in_flight && (cyc >= issue_cyc + 2);
`ifdef ARB_BYPASS_HOLD_EN
      if (in_flight && cyc == issue_cyc + 1 && rsp_ready[m_owner]) show = 1'b1;
`endif
      exp_rv = show ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (show && exp_q.size() > 0) begin
        chk("rsp_data", 64'(rsp_data), 64'(exp_q[0][31:0]));
        chk("rsp_flags", 64'(rsp_flags), 64'(exp_q[0][34:32]));
        if (rsp_ready[m_owner]) begin
          void'(exp_q.pop_front());
          in_flight = 1'b0;
        end
      end

      if (exp_ready != 2'b00) begin
        e_op = win ? req1_opcode : req0_opcode;
        e_sh = win ? req1_shamt  : req0_shamt;
        e_a  = win ? req1_a      : req0_a;
        e_b  = win ? req1_b      : req0_b;
        exp_q.push_back(alu_ref(e_op, e_sh, e_a, e_b));
        in_flight = 1'b1;
        issue_cyc = cyc;
        m_owner = win;
        m_last = win;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rand_req();
    req0_opcode = 5'($urandom_range(0, 6));
    req1_opcode = 5'($urandom_range(0, 6));
    req0_shamt  = 5'($urandom_range(0, 31));
    req1_shamt  = 5'($urandom_range(0, 31));
    req0_a = $urandom(); req0_b = $urandom();
    req1_a = $urandom(); req1_b = $urandom();
  endtask

  task automatic set_req(input logic sel, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sel) begin req1_opcode = op; req1_shamt = 5'd0; req1_a = a; req1_b = b; end
    else     begin req0_opcode = op; req0_shamt = 5'd0; req0_a = a; req0_b = b; end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rand_req();
    step(3);
    reset_n = 1'b1;
    step(1);

    // single request: AND
    set_req(1'b0, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step(4);

    // contention with results always accepted
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      rand_req();
      step(1);
    end
    req_valid = 2'b00;
    step(2);

    // backpressure while the ALU output wanders
    rsp_ready = 2'b00;
    set_req(1'b0, 5'd2, 32'h1234_5678, 32'h1111_1111);
    req_valid = 2'b01;
    step(1);
    set_req(1'b1, 5'd1, 32'h00FF_0000, 32'h0000_00FF);
    req_valid = 2'b10;
    noise_en = 1'b1;
    step(7);
    noise_en = 1'b0;
    rsp_ready = 2'b11;
    step(6);
    req_valid = 2'b00;
    step(2);

    // flags: signed overflow on SUB
    set_req(1'b1, 5'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    rsp_ready = 2'b10;
    req_valid = 2'b10;
    step(1);
    req_valid = 2'b00;
    step(4);

    // reset during EXEC, then contention must favour requester 0
    rsp_ready = 2'b00;
    set_req(1'b1, 5'd2, 32'd10, 32'd20);
    req_valid = 2'b10;
    step(1);
    reset_n = 1'b0;
    req_valid = 2'b11;
    step(1);
    reset_n = 1'b1;
    rsp_ready = 2'b11;
    step(4);
    req_valid = 2'b00;
    step(2);

    // ADD 3+4 with the owner already ready
    set_req(1'b0, 5'd2, 32'd3, 32'd4);
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    step(4);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rand_req();
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      reset_n   = ($urandom_range(0, 79) != 0);
      step(1);
    end
    reset_n = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(6);
    chk("drain_in_flight", 64'(in_flight), 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
